// File: rtl/boot_sequencer.sv
// boot_sequencer: copies the boot ROM image into instruction RAM, reads it
// back to verify, then releases the CPU and hands the RAM address port to
// the CPU program counter. A reload can be requested from RUN or ERROR.
module boot_sequencer #(
    parameter int BOOT_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_din,
    output logic        ram_we,
    input  logic [15:0] ram_dout,
    input  logic [15:0] cpu_pc,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] err_addr
);

    typedef enum logic [2:0] {
        INIT,
        COPY,
        VERIFY,
        RUN,
        ERROR
    } state_t;

    localparam logic [15:0] LAST   = 16'(BOOT_WORDS - 1);
    localparam logic [15:0] NWORDS = 16'(BOOT_WORDS);

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic        vld_p0;
    logic [15:0] exp_p0;
    logic [15:0] chk_addr_p0;
    logic [15:0] err_addr_r;

    logic        issue;
    logic        mismatch;
    logic        last_cmp;
    logic        reload;

    assign issue    = (state == VERIFY) && (cnt < NWORDS);
    assign mismatch = vld_p0 && (ram_dout != exp_p0);
    assign last_cmp = vld_p0 && (chk_addr_p0 == LAST);
    assign reload   = ((state == RUN) || (state == ERROR)) && start;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= INIT;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    state_nxt = COPY;
            COPY:    if (cnt == LAST) state_nxt = VERIFY;
            VERIFY: begin
                if (mismatch)      state_nxt = ERROR;
                else if (last_cmp) state_nxt = RUN;
            end
            RUN:     if (start) state_nxt = COPY;
            ERROR:   if (start) state_nxt = COPY;
            default: state_nxt = INIT;
        endcase
    end

    // Word counter shared by the copy and verify-issue passes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 16'd0;
        end else begin
            case (state)
                COPY:    cnt <= (cnt == LAST) ? 16'd0 : cnt + 16'd1;
                VERIFY:  if (issue) cnt <= cnt + 16'd1;
                default: cnt <= 16'd0;
            endcase
        end
    end

    // Verify issue -> compare stage boundary: valid flag for the pending read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_p0 <= 1'b0;
        else       vld_p0 <= issue && (state_nxt == VERIFY);
    end

    // Verify issue -> compare stage boundary: expected word and its address
    always_ff @(posedge clk) begin
        if (issue) begin
            exp_p0      <= rom_data;
            chk_addr_p0 <= cnt;
        end
    end

    // First mismatching address, held until a reload or reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                             err_addr_r <= 16'd0;
        else if (state == VERIFY && mismatch)  err_addr_r <= chk_addr_p0;
        else if (state == ERROR && reload)     err_addr_r <= 16'd0;
    end

    // Port muxing and status decoded from the registered state
    always_comb begin
        rom_addr = 16'd0;
        ram_addr = 16'd0;
        ram_din  = 16'd0;
        ram_we   = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            COPY: begin
                rom_addr = cnt;
                ram_addr = cnt;
                ram_din  = rom_data;
                ram_we   = 1'b1;
            end
            VERIFY: begin
                rom_addr = cnt;
                ram_addr = cnt;
            end
            RUN: begin
                ram_addr = cpu_pc;
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            ERROR:   error = 1'b1;
            default: ;
        endcase
    end

    assign err_addr = err_addr_r;

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer with BOOT_WORDS=4: directed vector table for the
// first boot, hand-written corner sequences, then random reload traffic
// checked against a cycle-timeline model of the boot.
module tb_boot_sequencer;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] rom_addr, rom_data, ram_addr, ram_din, ram_dout, cpu_pc, err_addr;
    logic        ram_we, cpu_hold, done, error;

    int vectors = 0;
    int miscompares = 0;

    // bench-side memories
    logic [15:0] rom [0:N-1];
    logic [15:0] mem [0:65535];
    logic        fault_en;
    logic [15:0] fault_addr;

    // timeline model: off = cycles since this boot began (0 = INIT)
    int off;
    int boot_f;

    localparam int S_INIT = 0, S_COPY = 1, S_VER = 2, S_RUN = 3, S_ERR = 4;

    boot_sequencer #(.BOOT_WORDS(N)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .cpu_pc(cpu_pc), .cpu_hold(cpu_hold), .done(done), .error(error),
        .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    assign rom_data = (rom_addr < 16'(N)) ? rom[rom_addr[1:0]] : 16'h0000;

    // RAM model: synchronous write with optional corruption, registered read
    always @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= (fault_en && ram_addr == fault_addr) ? 16'hFFFF : ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t off=%0d)", nm, act, exp, $time, off);
        end
    endtask

    function automatic int mstate();
        if (off == 0) return S_INIT;
        if (off <= N) return S_COPY;
        if (boot_f >= 0 && off >= N + 3 + boot_f) return S_ERR;
        if (boot_f < 0 && off >= 2 * N + 2) return S_RUN;
        return S_VER;
    endfunction

    task automatic model_check();
        int st;
        st = mstate();
        chk("cpu_hold", {15'd0, cpu_hold}, {15'd0, st != S_RUN});
        chk("done", {15'd0, done}, {15'd0, st == S_RUN});
        chk("error", {15'd0, error}, {15'd0, st == S_ERR});
        chk("err_addr", err_addr, (st == S_ERR) ? 16'(boot_f) : 16'd0);
        chk("ram_we", {15'd0, ram_we}, {15'd0, st == S_COPY});
        if (st == S_COPY) begin
            chk("copy_ram_addr", ram_addr, 16'(off - 1));
            chk("copy_rom_addr", rom_addr, 16'(off - 1));
            chk("copy_ram_din", ram_din, rom[off - 1]);
        end else if (st == S_VER && off <= 2 * N) begin
            chk("ver_ram_addr", ram_addr, 16'(off - N - 1));
            chk("ver_rom_addr", rom_addr, 16'(off - N - 1));
        end else if (st == S_RUN) begin
            chk("run_ram_addr", ram_addr, cpu_pc);
            chk("run_rom_addr", rom_addr, 16'd0);
        end
    endtask

    // advance one clock and move the model along
    task automatic adv();
        int st;
        int nxt;
        st  = mstate();
        nxt = ((st == S_RUN || st == S_ERR) && start) ? 1 : off + 1;
        @(posedge clk);
        #1;
        off = nxt;
        if (off == 1) boot_f = fault_en ? int'(fault_addr) : -1;
    endtask

    task automatic tick(input logic s, input logic [15:0] pc);
        start  = s;
        cpu_pc = pc;
        @(negedge clk);
        model_check();
        adv();
        start = 1'b0;
    endtask

    typedef struct {
        logic        st;
        logic [15:0] pc;
        logic        we, hold, dn, err;
        logic        ca;
        logic [15:0] addr;
        logic        cd;
        logic [15:0] din;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // first boot, cycles 0..11
        tbl[0]  = '{1'b0, 16'h0123, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 16'h0123, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0001};
        tbl[2]  = '{1'b0, 16'h0123, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 16'h0002};
        tbl[3]  = '{1'b0, 16'h0123, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 16'h0003};
        tbl[4]  = '{1'b0, 16'h0123, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1, 16'h0004};
        tbl[5]  = '{1'b1, 16'h0123, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
        tbl[6]  = '{1'b0, 16'h0123, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000};
        tbl[7]  = '{1'b0, 16'h0123, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 16'h0000};
        tbl[8]  = '{1'b0, 16'h0123, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 16'h0000};
        tbl[9]  = '{1'b0, 16'h0123, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        tbl[10] = '{1'b0, 16'h0123, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0123, 1'b0, 16'h0000};
        tbl[11] = '{1'b0, 16'h0456, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0456, 1'b0, 16'h0000};

        rom[0] = 16'h0001; rom[1] = 16'h0002; rom[2] = 16'h0003; rom[3] = 16'h0004;
        fault_en = 1'b0; fault_addr = 16'd0;
        reset = 1'b1; start = 1'b0; cpu_pc = 16'd0;
        off = 0; boot_f = -1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_hold", {15'd0, cpu_hold}, 16'd1);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_error", {15'd0, error}, 16'd0);
        chk("rst_ram_we", {15'd0, ram_we}, 16'd0);
        chk("rst_err_addr", err_addr, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        off = 0;

        // directed first boot from the table (start pulses in COPY/VERIFY are ignored)
        for (int i = 0; i < 12; i++) begin
            start  = tbl[i].st;
            cpu_pc = tbl[i].pc;
            @(negedge clk);
            chk($sformatf("tbl%0d_we", i), {15'd0, ram_we}, {15'd0, tbl[i].we});
            chk($sformatf("tbl%0d_hold", i), {15'd0, cpu_hold}, {15'd0, tbl[i].hold});
            chk($sformatf("tbl%0d_done", i), {15'd0, done}, {15'd0, tbl[i].dn});
            chk($sformatf("tbl%0d_error", i), {15'd0, error}, {15'd0, tbl[i].err});
            if (tbl[i].ca) chk($sformatf("tbl%0d_ram_addr", i), ram_addr, tbl[i].addr);
            if (tbl[i].cd) chk($sformatf("tbl%0d_ram_din", i), ram_din, tbl[i].din);
            adv();
        end
        start = 1'b0;
        for (int i = 0; i < N; i++) chk($sformatf("ram_image%0d", i), mem[i], rom[i]);

        // fault at address 2: reload from RUN, ERROR from boot cycle 9
        fault_en = 1'b1; fault_addr = 16'd2;
        tick(1'b1, 16'h0010);
        chk("reload_hold", {15'd0, cpu_hold}, 16'd1);
        chk("reload_done", {15'd0, done}, 16'd0);
        repeat (7) tick(1'b0, 16'h0010);
        chk("pre_err_error", {15'd0, error}, 16'd0);
        tick(1'b0, 16'h0010);
        chk("err_error", {15'd0, error}, 16'd1);
        chk("err_addr_val", err_addr, 16'd2);
        chk("err_hold", {15'd0, cpu_hold}, 16'd1);
        repeat (3) tick(1'b0, 16'h0010);
        chk("err_stays_addr", err_addr, 16'd2);
        chk("err_stays_done", {15'd0, done}, 16'd0);

        // clear fault, reload from ERROR, with stray start pulses during the boot
        fault_en = 1'b0;
        tick(1'b1, 16'h0020);
        chk("clr_error", {15'd0, error}, 16'd0);
        chk("clr_err_addr", err_addr, 16'd0);
        for (int k = 1; k < 2 * N + 2; k++) tick((k == 3) || (k == 7), 16'h0020);
        chk("reboot_done", {15'd0, done}, 16'd1);
        chk("reboot_hold", {15'd0, cpu_hold}, 16'd0);

        // reset asserted in the middle of COPY (boot cycle 2)
        tick(1'b1, 16'h0030);
        tick(1'b0, 16'h0030);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_hold", {15'd0, cpu_hold}, 16'd1);
        chk("async_rst_done", {15'd0, done}, 16'd0);
        chk("async_rst_we", {15'd0, ram_we}, 16'd0);
        chk("async_rst_error", {15'd0, error}, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        off = 0;
        repeat (2 * N + 2) tick(1'b0, 16'h0030);
        chk("post_rst_done", {15'd0, done}, 16'd1);

        // random reloads, cpu_pc traffic and fault patterns
        for (int c = 0; c < 400; c++) begin
            logic s;
            int   st;
            s  = ($urandom_range(0, 11) == 0);
            st = mstate();
            if (s && (st == S_RUN || st == S_ERR)) begin
                fault_en   = 1'($urandom_range(0, 1));
                fault_addr = 16'($urandom_range(0, N - 1));
            end
            tick(s, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/boot_sequencer.md
# boot_sequencer

Boot-time controller that owns the instruction-RAM port: after reset it holds the Hack CPU, copies the first BOOT_WORDS words of the boot ROM into instruction RAM, and reads the RAM back against the ROM. On a clean verify it releases the CPU and hands the RAM address port to the CPU program counter. It sits between ROM, instruction RAM and CPU and supports a software- or button-initiated reload.

## Interface
- BOOT_WORDS, 256: number of words copied and verified, range 1..65535.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  reload request, sampled only in RUN or ERROR.
- rom_addr  out  16  boot ROM address.
- rom_data  in  16  boot ROM word, combinational from rom_addr.
- ram_addr  out  16  instruction RAM address.
- ram_din  out  16  RAM write data.
- ram_we  out  1  RAM write enable; synchronous write.
- ram_dout  in  16  RAM read data, valid the cycle after ram_addr is presented.
- cpu_pc  in  16  CPU program counter.
- cpu_hold  out  1  drives the CPU reset input; 1 holds the CPU.
- done  out  1  boot complete and CPU running.
- error  out  1  verify mismatch.
- err_addr  out  16  address of the first mismatching word.

## Operation
- States: INIT, COPY, VERIFY, RUN, ERROR. The reset state is INIT.
- Reset values: cnt=0, chk_valid=0, err_addr=0, error=0, done=0, cpu_hold=1, ram_we=0.
- INIT: outputs idle. Goes to COPY on the next edge with cnt=0.
- COPY:
  - rom_addr=ram_addr=cnt, ram_din=rom_data, ram_we=1.
  - cnt increments each cycle.
  - After the write at cnt=BOOT_WORDS-1: cnt is set to 0 and the state goes to VERIFY.
- VERIFY issue stage, while cnt<BOOT_WORDS:
  - rom_addr=ram_addr=cnt, ram_we=0.
  - Registers exp<=rom_data, chk_addr<=cnt, chk_valid<=1.
  - cnt increments.
- VERIFY compare stage:
  - When chk_valid=1, compare ram_dout against exp.
  - On a mismatch: err_addr<=chk_addr, error<=1, next state ERROR. Later words are not compared.
  - After the compare of address BOOT_WORDS-1 with no mismatch: next state RUN.
- RUN:
  - ram_addr=cpu_pc, ram_we=0, cpu_hold=0, done=1. rom_addr=0.
  - start=1 sends the state to COPY next cycle with cnt=0. done drops and cpu_hold rises on that edge.
- ERROR:
  - cpu_hold=1, error=1, ram_we=0.
  - start=1 sends the state to COPY, clears error and err_addr, and sets cnt=0.
- start is ignored in INIT, COPY and VERIFY.
- Counter width: cnt is 16-bit and compared against BOOT_WORDS-1. It never wraps, because the transition occurs before overflow.
- Reset mid-operation: an immediate return to reset values. A partial RAM image is left as-is and is fully rewritten by the following COPY.
- Outputs are a function of registered state only. ram_addr, ram_din and rom_addr are the exception: they carry the combinational pass-through of cnt, rom_data or cpu_pc.

## Timing
- Cycle 0 is the first cycle after reset deasserts.
- Cycle 0: INIT.
- Cycles 1..N (N=BOOT_WORDS): COPY. Cycle k writes address k-1.
- Cycles N+1..2N: VERIFY issues reads for addresses 0..N-1.
- Cycles N+2..2N+1: compares for addresses 0..N-1.
- Cycle 2N+2: RUN, with cpu_hold=0 and done=1.
- A mismatch found at compare cycle c gives ERROR from cycle c+1, with error=1 and err_addr valid.
- start asserted in cycle t (RUN or ERROR): COPY from t+1 and writes address 0 in t+1. RUN again at t+2N+2.
- No combinational path from ram_dout to any output.

## Test plan
- Reset with BOOT_WORDS=4 and ROM={0x0001,0x0002,0x0003,0x0004}, RAM model correct:
  - ram_we=1 in cycles 1..4 at addresses 0..3 with matching data.
  - done=1 and cpu_hold=0 at cycle 10.
  - error=0.
- Fault injection, RAM model corrupts address 2 (stores 0xFFFF):
  - error=1 and err_addr=2 from cycle 9.
  - cpu_hold stays 1 and done stays 0.
  - No compare of address 3 affects state.
- In RUN, drive cpu_pc=0x0123: ram_addr=0x0123 in the same cycle and ram_we=0.
- Pulse start for 1 cycle in RUN:
  - cpu_hold=1 and done=0 next cycle.
  - A full copy and verify follow, and RUN returns 2N+2 cycles after the start cycle.
- Assert reset in the middle of COPY (cycle 2): all outputs return to reset values asynchronously. Boot restarts and completes with the normal timing after release.
- From ERROR, clear the fault and pulse start:
  - error=0 and err_addr=0 in the next cycle.
  - Boot completes with done=1.
- Pulse start during COPY or VERIFY: no effect on the sequence or the cycle counts.
